clk_div_monitor: RTL and testbench

//  Receive side of the clock divider outputs: samples a slow divided clock (clk_in) in the clk domain,

---
 rtl/clk_div_monitor.sv | 91 +++++++++
 tb/tb_clk_div_monitor.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures the period of a divided clock in clk cycles,
// compares it with an expected ratio and reports lock, mismatch and timeout errors
module clk_div_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clk_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period_o,
  output logic             period_vld,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_count
);
  typedef enum logic [1:0] {IDLE, ARM, ACQ, LOCKED} state_t;
  localparam logic [CNT_W-1:0] MAX   = '1;
  localparam logic [CNT_W:0]   TOL_V = (CNT_W+1)'(TOL);
  localparam logic [7:0]       LOCK_V = 8'(LOCK_CNT);
  state_t state_q, state_d;
  logic [2:0] sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic to_q, to_d, vld_q, vld_d, err_q, err_d;
  logic [7:0] match_cnt_q, match_cnt_d, err_count_q, err_count_d;
  logic rise, timeout, match, report, active;
  logic [CNT_W:0] meas, diff;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    rise = sync_q[1] & ~sync_q[2];
    meas = {1'b0, cnt_q} + 1'b1;
    diff = meas >= {1'b0, exp_period} ? meas - {1'b0, exp_period} : {1'b0, exp_period} - meas;
    match = diff <= TOL_V;
    // timeout fires once per saturation; to_q remembers it until the next rise
    timeout = (cnt_q == MAX) & ~to_q & ~rise;
    active = enable & (state_q == ACQ | state_q == LOCKED);
    report = active & rise;
    state_d = state_q;
    if (!enable) state_d = IDLE;
    else
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     state_d = rise ? ACQ : ARM;
        ACQ:     state_d = (report & match & (match_cnt_q + 8'd1 == LOCK_V)) ? LOCKED : timeout ? ARM : ACQ;
        default: state_d = (report & ~match) ? ACQ : timeout ? ARM : LOCKED;
      endcase
  end
  always_comb begin
    sync_d = {sync_q[1:0], clk_in};
    cnt_d = (!enable | state_q == IDLE | rise) ? '0 : (cnt_q == MAX) ? MAX : cnt_q + 1'b1;
    to_d = (!enable | state_q == IDLE | rise) ? 1'b0 : to_q | timeout;
    period_d = report ? ((cnt_q == MAX) ? MAX : meas[CNT_W-1:0]) : period_q;
    vld_d = report;
    match_cnt_d = (!active | timeout | (report & ~match)) ? 8'd0 :
                  (report & match_cnt_q != LOCK_V) ? match_cnt_q + 8'd1 : match_cnt_q;
    err_d = enable & state_q == LOCKED & ((report & ~match) | timeout);
    err_count_d = err_clr ? 8'd0 : (err_d & err_count_q != 8'hff) ? err_count_q + 8'd1 : err_count_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      to_q        <= 1'b0;
      period_q    <= '0;
      vld_q       <= 1'b0;
      match_cnt_q <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      period_q    <= period_d;
      vld_q       <= vld_d;
      match_cnt_q <= match_cnt_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  always_comb begin
    locked     = state_q == LOCKED;
    period_o   = period_q;
    period_vld = vld_q;
    err        = err_q;
    err_count  = err_count_q;
  end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: scoreboard bench; stimulus queues expected periods, a monitor checks each report
module tb_clk_div_monitor;
  logic clk = 0, reset = 0, enable = 0, clk_in = 0, err_clr = 0;
  logic [7:0] exp_period = 8'd4;
  logic [7:0] period_o, err_count;
  logic period_vld, locked, err;
  int total = 0, bad = 0, err_seen = 0, last_p = 0, waited;
  int exp_q[$];

  clk_div_monitor dut (
    .clk(clk), .reset(reset), .enable(enable), .clk_in(clk_in), .exp_period(exp_period),
    .err_clr(err_clr), .period_o(period_o), .period_vld(period_vld), .locked(locked),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  // each cycle of clk_in starts with a rising edge; the report for that edge carries the previous gap
  task automatic run(int p, int n, bit arm);
    for (int i = 0; i < n; i++) begin
      if (!(arm && i == 0)) exp_q.push_back(last_p);
      clk_in = 1;
      repeat (p / 2) @(negedge clk);
      clk_in = 0;
      repeat (p - p / 2) @(negedge clk);
      last_p = p;
    end
  endtask

  task automatic restart(int e);
    enable = 0;
    repeat (3) @(negedge clk);
    exp_period = 8'(e);
    enable = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_err(output int cyc);
    cyc = 0;
    while (!err && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  always @(negedge clk) if (reset) begin
    if (period_vld) begin
      if (exp_q.size() == 0) chk("unexpected_period_vld", 1, 0);
      else chk("period_o", period_o, exp_q.pop_front());
    end
    if (err) begin
      err_seen++;
      chk("locked_with_err", locked, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_period_o", period_o, 0);
    chk("rst_period_vld", period_vld, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    reset = 1;
    @(negedge clk);
    restart(4);
    // clk/8 against exp 4: reports 8, never locks, no error
    run(8, 6, 1);
    chk("t2_locked", locked, 0);
    chk("t2_err_seen", err_seen, 0);
    // clk/4 against exp 4: lock after arm + 4 matches
    restart(4);
    run(4, 4, 1);
    chk("t1_locked_early", locked, 0);
    run(4, 2, 0);
    chk("t1_locked", locked, 1);
    // switch to clk/8 while locked: one error, then relock at exp 8
    run(8, 3, 0);
    chk("t3_err_seen", err_seen, 1);
    chk("t3_err_count", err_count, 1);
    chk("t3_locked_lost", locked, 0);
    exp_period = 8'd8;
    run(8, 5, 0);
    chk("t3_relocked", locked, 1);
    // clk_in stalls while locked: timeout error, back to ARM
    wait_err(waited);
    chk("t4_err", err, 1);
    chk("t4_delay_ok", int'(waited >= 240 && waited <= 270), 1);
    @(negedge clk);
    chk("t4_err_count", err_count, 2);
    chk("t4_locked", locked, 0);
    run(8, 5, 1);
    chk("t4_relock_from_arm", locked, 1);
    // tolerance: period 5 locks on exp 4, period 6 does not
    restart(4);
    run(5, 6, 1);
    chk("t5_p5_locked", locked, 1);
    restart(4);
    run(6, 6, 1);
    chk("t5_p6_locked", locked, 0);
    chk("t5_no_err", err_seen, 2);
    // err_clr held across a timeout error wins over the increment
    restart(4);
    run(5, 6, 1);
    chk("t5_relock", locked, 1);
    err_clr = 1;
    wait_err(waited);
    chk("t5_err", err, 1);
    chk("t5_err_count_clr", err_count, 0);
    @(negedge clk);
    err_clr = 0;
    // enable drop while locked: locked clears, period_o holds
    restart(4);
    run(4, 6, 1);
    chk("t6_locked", locked, 1);
    enable = 0;
    @(negedge clk);
    chk("t6_dis_locked", locked, 0);
    chk("t6_dis_period", period_o, 4);
    enable = 1;
    repeat (2) @(negedge clk);
    run(4, 6, 1);
    chk("t6_relock", locked, 1);
    #3 reset = 0;
    #1;
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_period", period_o, 0);
    chk("t6_rst_err_count", err_count, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
